// File: rtl/spi_xfer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// spi_xfer_sequencer_pkg
//   Shared definitions for the SPI transfer sequencer: default widths and the
//   sequencer state encoding (IDLE=0 .. GAP=5, 3 bits).
// -----------------------------------------------------------------------------
package spi_xfer_sequencer_pkg;

    localparam int SPI_DIVIDER_LEN = 16;
    localparam int SPI_SS_NB       = 8;
    localparam int SPI_DLY_LEN     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GO    = 3'd2,
        ST_RUN   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } xfer_state_e;

    // States in which the automatic slave select is driven low.
    function automatic logic ss_active(input xfer_state_e st);
        return (st == ST_SETUP) || (st == ST_GO) || (st == ST_RUN) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
//   Down-counter with reload. Used both for the sclk half-period and for the
//   SETUP/HOLD/GAP delays: a value V loaded into it produces a tick V+1 cycles
//   later, after which it reloads V by itself.
// Ports
//   wb_clk_in, wb_rst : clock, asynchronous active-high reset
//   en                : count enable
//   load              : force-load divider (takes priority over counting)
//   divider           : load / reload value
//   tick              : count reached zero while enabled
// -----------------------------------------------------------------------------
module spi_clk_div
    import spi_xfer_sequencer_pkg::*;
#(
    parameter int DIV_W = SPI_DIVIDER_LEN
) (
    input  logic             wb_clk_in,
    input  logic             wb_rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] divider,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = divider;
        end else if (en) begin
            // reload at zero, so the counter never wraps
            cnt_d = (cnt_q == '0) ? divider : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// spi_xfer_sequencer
//   Timing stage ahead of the SPI shift register. Sequences slave select
//   around each character (SETUP, GO, RUN, HOLD, GAP) and generates sclk with
//   its cpol_0 (rise) / cpol_1 (fall) strobes. All outputs are registered.
// Ports
//   wb_clk_in, wb_rst : clock, asynchronous active-high reset
//   start             : transfer request (ignored while busy)
//   divider, ss_sel, cs_setup, cs_hold, cs_gap : sampled on an accepted start
//   ass               : 1 = FSM drives ss_pad_o, 0 = ss_pad_o follows ~ss_sel
//   tip               : transfer in progress from the shift register
//   go                : 1-cycle pulse starting the shift register
//   sclk, cpol_0, cpol_1 : serial clock and edge strobes
//   ss_pad_o          : active-low slave selects
//   busy, done        : not-idle flag, 1-cycle completion pulse
// -----------------------------------------------------------------------------
module spi_xfer_sequencer
    import spi_xfer_sequencer_pkg::*;
#(
    parameter int DIV_W = SPI_DIVIDER_LEN,
    parameter int SS_NB = SPI_SS_NB,
    parameter int DLY_W = SPI_DLY_LEN
) (
    input  logic             wb_clk_in,
    input  logic             wb_rst,
    input  logic             start,
    input  logic [DIV_W-1:0] divider,
    input  logic             ass,
    input  logic [SS_NB-1:0] ss_sel,
    input  logic [DLY_W-1:0] cs_setup,
    input  logic [DLY_W-1:0] cs_hold,
    input  logic [DLY_W-1:0] cs_gap,
    input  logic             tip,
    output logic             go,
    output logic             sclk,
    output logic             cpol_0,
    output logic             cpol_1,
    output logic [SS_NB-1:0] ss_pad_o,
    output logic             busy,
    output logic             done
);

    xfer_state_e      state_q, state_d;
    logic [DIV_W-1:0] divider_q, divider_d;
    logic [SS_NB-1:0] ss_sel_q, ss_sel_d;
    logic [DLY_W-1:0] cs_setup_q, cs_setup_d;
    logic [DLY_W-1:0] cs_hold_q, cs_hold_d;
    logic [DLY_W-1:0] cs_gap_q, cs_gap_d;

    logic             go_q, go_d;
    logic             sclk_q, sclk_d;
    logic             cpol_0_q, cpol_0_d;
    logic             cpol_1_q, cpol_1_d;
    logic [SS_NB-1:0] ss_q, ss_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tick;
    logic             cnt_load;
    logic [DIV_W-1:0] cnt_val;

    // State, sampled parameters and output registers.
    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state_q    <= ST_IDLE;
            divider_q  <= '0;
            ss_sel_q   <= '0;
            cs_setup_q <= '0;
            cs_hold_q  <= '0;
            cs_gap_q   <= '0;
            go_q       <= 1'b0;
            sclk_q     <= 1'b0;
            cpol_0_q   <= 1'b0;
            cpol_1_q   <= 1'b0;
            ss_q       <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            divider_q  <= divider_d;
            ss_sel_q   <= ss_sel_d;
            cs_setup_q <= cs_setup_d;
            cs_hold_q  <= cs_hold_d;
            cs_gap_q   <= cs_gap_d;
            go_q       <= go_d;
            sclk_q     <= sclk_d;
            cpol_0_q   <= cpol_0_d;
            cpol_1_q   <= cpol_1_d;
            ss_q       <= ss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state; transfer parameters are captured on the accepted start.
    always_comb begin
        state_d    = state_q;
        divider_d  = divider_q;
        ss_sel_d   = ss_sel_q;
        cs_setup_d = cs_setup_q;
        cs_hold_d  = cs_hold_q;
        cs_gap_d   = cs_gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETUP;
                    divider_d  = divider;
                    ss_sel_d   = ss_sel;
                    cs_setup_d = cs_setup;
                    cs_hold_d  = cs_hold;
                    cs_gap_d   = cs_gap;
                end
            end
            ST_SETUP: if (tick) state_d = ST_GO;
            ST_GO:    state_d = ST_RUN;
            ST_RUN:   if (!tip && !sclk_q) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_GAP;
            ST_GAP:   if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The shared counter is reloaded on every state change with the count
    // belonging to the state being entered (the _d values, so a freshly
    // accepted start is already visible).
    always_comb begin
        case (state_d)
            ST_SETUP: cnt_val = DIV_W'(cs_setup_d);
            ST_RUN:   cnt_val = divider_d;
            ST_HOLD:  cnt_val = DIV_W'(cs_hold_d);
            ST_GAP:   cnt_val = DIV_W'(cs_gap_d);
            default:  cnt_val = '0;
        endcase
    end

    assign cnt_load = (state_d != state_q);

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .wb_clk_in (wb_clk_in),
        .wb_rst    (wb_rst),
        .en        (state_q != ST_IDLE),
        .load      (cnt_load),
        .divider   (cnt_val),
        .tick      (tick)
    );

    // Output next values. Strobes are computed together with the sclk edge
    // so each one appears in the first cycle sclk shows its new level.
    always_comb begin
        go_d     = (state_d == ST_GO);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_GAP) && (state_d == ST_IDLE);
        sclk_d   = 1'b0;
        cpol_0_d = 1'b0;
        cpol_1_d = 1'b0;
        if (state_q == ST_GO) begin
            cpol_0_d = 1'b1;                 // priming strobe for the first bit
        end else if (state_q == ST_RUN) begin
            sclk_d = sclk_q;
            if (tick) begin
                if (sclk_q) begin
                    sclk_d   = 1'b0;
                    cpol_1_d = 1'b1;
                end else if (tip) begin      // no rise once the character is over
                    sclk_d   = 1'b1;
                    cpol_0_d = 1'b1;
                end
            end
        end
        if (ass) ss_d = ss_active(state_d) ? ~ss_sel_d : '1;
        else     ss_d = ~ss_sel;
    end

    assign go       = go_q;
    assign sclk     = sclk_q;
    assign cpol_0   = cpol_0_q;
    assign cpol_1   = cpol_1_q;
    assign ss_pad_o = ss_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
